// File: rtl/switch_gate_debounce.sv
// Switch debouncer with a selectable gate on the debounced levels.
// Each raw switch is synchronised, then debounced by a per-channel
// counter. The debounced vector drives a gate (AND / OR / XOR) or a
// toggle bit that flips on every release of the all-pressed state.
module switch_gate_debounce #(
  parameter int NUM_SW         = 2,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_SW-1:0] i_Sw,
  input  logic [1:0]        i_Mode,
  output logic [NUM_SW-1:0] o_Sw_Db,
  output logic              o_Led,
  output logic              o_Change
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  // Counter value on the last differing cycle before a change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    MODE_AND    = 2'b00,
    MODE_OR     = 2'b01,
    MODE_XOR    = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_t;

  logic [NUM_SW-1:0] sync1_r;
  logic [NUM_SW-1:0] sync2_r;
  logic [CNT_W-1:0]  cnt_r [NUM_SW];
  // Accepted level; o_Sw_Db is its registered copy, one cycle later.
  logic [NUM_SW-1:0] stable_r;
  logic              and_prev_r;
  logic              toggle_r;

  mode_t mode_s;
  logic  gate_and_s;
  logic  gate_or_s;
  logic  gate_xor_s;
  logic  toggle_fall_s;
  logic  led_next_s;

  // Select the gate result that o_Led should present for a given mode.
  function automatic logic select_led(
    input mode_t m,
    input logic  g_and,
    input logic  g_or,
    input logic  g_xor,
    input logic  tgl
  );
    logic r;
    case (m)
      MODE_AND:    r = g_and;
      MODE_OR:     r = g_or;
      MODE_XOR:    r = g_xor;
      MODE_TOGGLE: r = tgl;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= i_Sw;
      sync2_r <= sync1_r;
    end
  end

  // Per-channel debounce counters; channels never interact.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_r[i] <= '0;
      end
      stable_r <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          // Back at the stable level: any partial count was a glitch.
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          // This differing cycle completes the run: accept and restart.
          stable_r[i] <= sync2_r[i];
          cnt_r[i]    <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registered debounced outputs and the single-cycle change pulse.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Sw_Db  <= '0;
      o_Change <= 1'b0;
    end else begin
      o_Sw_Db  <= stable_r;
      o_Change <= |(stable_r ^ o_Sw_Db);
    end
  end

  // Gate functions over the current debounced vector.
  always_comb begin
    mode_s        = mode_t'(i_Mode);
    gate_and_s    = &o_Sw_Db;
    gate_or_s     = |o_Sw_Db;
    gate_xor_s    = ^o_Sw_Db;
    toggle_fall_s = 1'b0;
    if ((mode_s == MODE_TOGGLE) && and_prev_r && !gate_and_s) begin
      toggle_fall_s = 1'b1;
    end else begin
      toggle_fall_s = 1'b0;
    end
    led_next_s = select_led(mode_s, gate_and_s, gate_or_s, gate_xor_s, toggle_r);
  end

  // Toggle bit and registered LED. and_prev_r tracks AND in every mode so
  // entering TOGGLE never sees a stale history and cannot toggle spuriously.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      and_prev_r <= 1'b0;
      toggle_r   <= 1'b0;
      o_Led      <= 1'b0;
    end else begin
      and_prev_r <= gate_and_s;
      if (toggle_fall_s) begin
        toggle_r <= ~toggle_r;
      end else begin
        toggle_r <= toggle_r;
      end
      o_Led <= led_next_s;
    end
  end

endmodule

// File: tb/tb_switch_gate_debounce.sv
// Scoreboard bench for switch_gate_debounce (NUM_SW=2, DEBOUNCE_LIMIT=4).
// Stimulus pushes expected output events (debounced change or LED change)
// with the cycle they must appear on; a monitor pops and compares them.
module tb_switch_gate_debounce;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic [1:0] i_Sw;
  logic [1:0] i_Mode;
  logic [1:0] o_Sw_Db;
  logic       o_Led;
  logic       o_Change;

  typedef struct {
    int         cyc;
    bit         is_led;
    logic [1:0] val;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic       exp_led = 1'b0;
  logic [1:0] prev_db;
  logic       prev_led;

  switch_gate_debounce #(
    .NUM_SW(2),
    .DEBOUNCE_LIMIT(4)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_Sw(i_Sw),
    .i_Mode(i_Mode),
    .o_Sw_Db(o_Sw_Db),
    .o_Led(o_Led),
    .o_Change(o_Change)
  );

  always #5 i_Clk = ~i_Clk;

  // Rising-edge counter; after posedge n the monitor sees cyc == n.
  initial begin
    forever begin
      @(posedge i_Clk);
      cyc++;
    end
  end

  function automatic void push(input int c, input bit l, input logic [1:0] v);
    ev_t e;
    e.cyc    = c;
    e.is_led = l;
    e.val    = v;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic match_event(input bit is_led, input logic [1:0] val, input logic pulse);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected: got %b at cyc %0d, expected no event",
               is_led ? "led" : "sw_db", val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_led !== is_led || e.cyc != cyc || e.val !== val || pulse !== 1'b1) begin
        errors++;
        $display("FAIL %s: got val=%b pulse=%b at cyc %0d, expected %s val=%b at cyc %0d",
                 is_led ? "led" : "sw_db", val, pulse, cyc,
                 e.is_led ? "led" : "sw_db", e.val, e.cyc);
      end
    end
  endtask

  // Monitor: any debounced change, change pulse or LED edge is an event.
  initial begin
    prev_db  = 2'b00;
    prev_led = 1'b0;
    forever begin
      @(negedge i_Clk);
      if (i_Rst) begin
        prev_db  = 2'b00;
        prev_led = 1'b0;
      end else begin
        if (o_Change || (o_Sw_Db != prev_db)) begin
          match_event(1'b0, o_Sw_Db, o_Change);
        end
        if (o_Led != prev_led) begin
          match_event(1'b1, {1'b0, o_Led}, 1'b1);
        end
        prev_db  = o_Sw_Db;
        prev_led = o_Led;
      end
    end
  end

  // Drive a clean switch step at a negedge and record its expected events.
  task automatic step(input logic [1:0] v, input logic led_after, input int lat);
    int e0;
    i_Sw = v;
    e0   = cyc + 1;
    push(e0 + 6, 1'b0, v);
    if (led_after != exp_led) begin
      push(e0 + lat, 1'b1, {1'b0, led_after});
      exp_led = led_after;
    end
    repeat (20) @(negedge i_Clk);
  endtask

  task automatic set_mode(input logic [1:0] m, input logic led_after);
    i_Mode = m;
    if (led_after != exp_led) begin
      push(cyc + 1, 1'b1, {1'b0, led_after});
      exp_led = led_after;
    end
    repeat (5) @(negedge i_Clk);
  endtask

  logic [1:0] seq_v   [4];
  logic [3:0] led_tab [3];
  int         e0;

  initial begin
    seq_v   = '{2'b01, 2'b10, 2'b11, 2'b00};
    // LED after each step, bit s for step s: AND, OR, XOR.
    led_tab = '{4'b0100, 4'b0111, 4'b0011};
    i_Rst  = 1'b1;
    i_Sw   = 2'b00;
    i_Mode = 2'b00;
    repeat (3) @(negedge i_Clk);
    chk("reset_sw_db", {2'b00, o_Sw_Db}, 4'h0);
    chk("reset_led", {3'b000, o_Led}, 4'h0);
    chk("reset_change", {3'b000, o_Change}, 4'h0);
    i_Rst = 1'b0;
    repeat (3) @(negedge i_Clk);

    // Gate modes over the 01,10,11,00 step sequence.
    for (int m = 0; m < 3; m++) begin
      set_mode(2'(m), 1'b0);
      for (int s = 0; s < 4; s++) begin
        step(seq_v[s], led_tab[m][s], 7);
      end
    end

    // Bounce on sw[0]: 3 high / 1 low five times, then steady high.
    set_mode(2'b00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      i_Sw = 2'b01;
      repeat (3) @(negedge i_Clk);
      i_Sw = 2'b00;
      repeat (1) @(negedge i_Clk);
    end
    step(2'b01, 1'b0, 7);
    step(2'b00, 1'b0, 7);

    // Toggle: three press/release pairs; LED flips 8 cycles after release.
    set_mode(2'b11, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(2'b11, exp_led, 8);
      step(2'b00, ~exp_led, 8);
    end

    // Leave TOGGLE with the bit set and come back: no extra toggle.
    set_mode(2'b00, 1'b0);
    set_mode(2'b11, 1'b1);

    // Reset between edges with count 2 on both channels.
    i_Sw = 2'b11;
    repeat (4) @(posedge i_Clk);
    #2;
    i_Rst = 1'b1;
    #1;
    chk("midrst_sw_db", {2'b00, o_Sw_Db}, 4'h0);
    chk("midrst_led", {3'b000, o_Led}, 4'h0);
    chk("midrst_change", {3'b000, o_Change}, 4'h0);
    repeat (2) @(negedge i_Clk);
    i_Rst   = 1'b0;
    exp_led = 1'b0;
    e0      = cyc + 1;
    push(e0 + 6, 1'b0, 2'b11);
    repeat (20) @(negedge i_Clk);
    step(2'b00, 1'b1, 8);

    // Simultaneous change on both channels in AND mode.
    set_mode(2'b00, 1'b0);
    step(2'b11, 1'b1, 7);

    repeat (10) @(negedge i_Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, expected 0 (next at cyc %0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_gate_debounce.md
SWITCH_GATE_DEBOUNCE -- requirements
Module: switch_gate_debounce

Interface
REQ-001 Parameter NUM_SW, default 2, number of switch channels; legal range 2..16.
REQ-002 Parameter DEBOUNCE_LIMIT, default 250000, is the number of consecutive cycles a synchronised input must differ from its stable value before the change is accepted; legal minimum 2.
REQ-003 i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_Rst  input  1  reset, asynchronous and active-high.
REQ-005 i_Sw  input  NUM_SW  raw, asynchronous switch levels; 1 = pressed.
REQ-006 i_Mode  input  2  gate mode: 00 AND, 01 OR, 10 XOR, 11 TOGGLE; sampled synchronously.
REQ-007 o_Sw_Db  output  NUM_SW  debounced, registered switch levels.
REQ-008 o_Led  output  1  registered gate result.
REQ-009 o_Change  output  1  single-cycle pulse whenever any bit of o_Sw_Db changes.

Function
REQ-010 Each i_Sw bit shall pass through a 2-flop synchroniser before debouncing.
REQ-011 Each channel shall have an independent counter of width $clog2(DEBOUNCE_LIMIT+1).
REQ-012 Counter behaviour: cleared when synchronised bit equals o_Sw_Db bit; incremented when it differs.
REQ-013 When the counter would reach DEBOUNCE_LIMIT, o_Sw_Db bit shall take the synchronised value and the counter shall clear in the same cycle.
REQ-014 A return to the stable value before DEBOUNCE_LIMIT differing cycles shall clear the counter with no output change (glitch rejection).
REQ-015 Latency: a clean i_Sw step held steadily shall appear on o_Sw_Db exactly DEBOUNCE_LIMIT+2 cycles after the first rising edge that samples it.
REQ-016 Gate functions over all NUM_SW debounced bits: AND = &o_Sw_Db, OR = |o_Sw_Db, XOR = ^o_Sw_Db.
REQ-017 Modes 00/01/10: o_Led shall equal the selected function of the current o_Sw_Db, registered, i.e. one cycle after o_Sw_Db changes.
REQ-018 TOGGLE mode: an internal toggle bit shall invert on each cycle where the AND function goes 1->0 (falling edge of all-pressed), and o_Led shall equal the toggle bit one cycle later.
REQ-019 The toggle bit shall update only while i_Mode = 11 and shall hold its value in other modes.
REQ-020 Mode change: o_Led shall reflect the new mode's result on the cycle after i_Mode is sampled changed; no spurious toggle on mode entry.
REQ-021 o_Change shall be high for exactly one cycle, coincident with the cycle o_Sw_Db first shows the new value; simultaneous changes on several channels shall produce one pulse.
REQ-022 Channels shall be fully independent; simultaneous transitions on all channels shall each complete with REQ-015 latency.

Reset
REQ-023 While i_Rst is high: synchroniser flops, counters, o_Sw_Db, toggle bit, o_Led and o_Change shall be 0, asynchronously, without waiting for i_Clk.
REQ-024 Reset asserted mid-debounce shall discard the partial count; after release, debouncing restarts from stable value 0.
REQ-025 After i_Rst deasserts, switches held high shall reach o_Sw_Db after DEBOUNCE_LIMIT+2 cycles, per REQ-015.

Verification (bench uses NUM_SW=2, DEBOUNCE_LIMIT=4)
REQ-026 Step sw=00->01->10->11, 20 cycles each, mode AND -> o_Led 0,0,0,1; mode OR -> 0,1,1,1; mode XOR -> 0,1,1,0; each o_Led change 7 cycles after the i_Sw edge.
REQ-027 Bounce: sw[0] pulses high for 3 cycles, low for 1, repeated 5 times, then held high -> o_Sw_Db[0] stays 0 during bouncing and rises 6 cycles after the final steady edge; one o_Change pulse.
REQ-028 TOGGLE: press and release sw=11 three times, 20 cycles each -> o_Led 0->1->0->1, each toggle occurring 8 cycles after the release edge.
REQ-029 Mode switch: toggle bit = 1 in TOGGLE; switch to AND with sw=00 -> o_Led 0; return to TOGGLE -> o_Led 1 with no extra toggle.
REQ-030 Reset mid-operation: sw=11 held, assert i_Rst asynchronously between clock edges at count 2 -> all outputs 0 immediately; release -> o_Sw_Db = 11 exactly 6 cycles later.
REQ-031 Simultaneous change: sw 00->11 on one edge -> both o_Sw_Db bits rise on the same cycle, with a single o_Change pulse.
